keypad_debounce_encoder: RTL
============================

Name: keypad_debounce_encoder

Overview:
Front-end conditioner for the door-lock keypad. It sits directly upstream of the lock FSM and takes three raw, bouncy, asynchronous key contacts (key 1, key 2, star). It synchronizes and debounces them, then emits exactly one single-cycle code pulse per accepted press on button_2_1 / button_star, which the lock FSM consumes. Simultaneous multi-key presses are rejected and flagged.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a press or a release; must be >= 1.
CNT_W, 5, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
key_1_raw  input  1  raw contact for key 1, active high, asynchronous
key_2_raw  input  1  raw contact for key 2, active high, asynchronous
key_star_raw  input  1  raw contact for star key, active high, asynchronous
button_2_1  output  2  registered code pulse: 2'b01 = key 1, 2'b10 = key 2, 2'b00 = idle
button_star  output  1  registered single-cycle pulse for an accepted star press
multi_err  output  1  registered single-cycle pulse when more than one key is detected
key_busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: n_rst is asynchronous and active-low; clk is the clock. On reset:
  - State goes to IDLE and the counter clears to 0.
  - The sync flops and the candidate register clear to 0.
  - button_2_1 = 2'b00, button_star = 0, multi_err = 0, key_busy = 0.
- Synchronizer: each raw key passes through a 2-flop synchronizer. kv[2:0] = {star, key2, key1} is taken from the second stage. The FSM sees only kv.
- IDLE:
  - kv == 0: stay in IDLE.
  - Exactly one bit set: cand <= kv, cnt <= 0, go to DEBOUNCE.
  - More than one bit set: pulse multi_err, cnt <= 0, go to WAIT_REL.
- DEBOUNCE:
  - kv == cand and cnt == DEBOUNCE_CYCLES-1: go to EMIT and load the output registers from cand.
  - kv == cand otherwise: cnt++.
  - kv != cand (bounce, release, or another key): go to IDLE with no output. IDLE re-evaluates kv on the next edge.
- EMIT (lasts exactly 1 cycle):
  - Output registers hold the pulse: button_2_1 = {cand[1], cand[0]}, button_star = cand[2].
  - Next state is WAIT_REL, cnt <= 0, and the output registers clear on that same edge.
- WAIT_REL:
  - kv == 0: cnt++. When cnt == DEBOUNCE_CYCLES-1 and kv == 0, go to IDLE.
  - Any nonzero kv: cnt <= 0 and stay in WAIT_REL. Holding a key, or pressing a second key while one is held, never produces a second pulse.
- Pulse invariants:
  - button_2_1 and button_star are never both nonzero.
  - button_2_1 never equals 2'b11.
  - All pulses are exactly 1 clk wide.
- Latency: let t0 be the first edge at which sync stage 1 samples a press that stays stable.
  - The pulse is high from edge t0+DEBOUNCE_CYCLES+2 to edge t0+DEBOUNCE_CYCLES+3.
  - A release must stay stable for DEBOUNCE_CYCLES cycles in WAIT_REL before the next press can be accepted.
- multi_err:
  - Asserts for 1 cycle on the IDLE->WAIT_REL transition only.
  - It does not assert for a second key appearing during DEBOUNCE; that case aborts the press silently via IDLE.
- key_busy = (state != IDLE), registered or decoded from the state register.
- Counter: saturates and never wraps. Only the values 0..DEBOUNCE_CYCLES-1 are ever reached.
- Reset mid-operation: any state aborts immediately and no pulse is emitted. A key still held after reset release is treated as a new press and is debounced and emitted normally.
- Illegal state encodings recover to IDLE on the next edge with all outputs at 0.

Test Plan:
1. DEBOUNCE_CYCLES=4, reset, hold key_1_raw high from edge t0 for 20 cycles -> button_2_1 = 2'b01 for exactly 1 cycle after edge t0+6; no further pulse while held; key_busy stays high until 4 idle cycles after release.
2. Press key_2_raw cleanly -> button_2_1 = 2'b10 for 1 cycle. Press key_star_raw cleanly -> button_star = 1 for 1 cycle with button_2_1 = 2'b00.
3. Bounce key_1_raw high 2 cycles, low 1, high 2, low 1, then stable high -> exactly one 2'b01 pulse, 6 cycles after the start of the final stable period.
4. key_1_raw and key_2_raw rise on the same edge and are held 10 cycles -> multi_err pulses once 2 cycles after the rise; button_2_1 stays 2'b00; after release and 4 idle cycles, key_busy = 0.
5. Hold key_1_raw; pull n_rst low mid-DEBOUNCE for 2 cycles -> all outputs 0 during reset; after release, 2'b01 is emitted 6 cycles after the first post-reset sampling edge.
6. Key 1 pressed and released cleanly, then key 2 pressed during the release window (cnt=2) -> cnt restarts; key 2 produces no pulse until it is fully released and pressed again.

Source files
------------

// File: rtl/keypad_debounce_encoder.sv
// Synchronizes and debounces three raw keypad contacts and emits one single-cycle code pulse per
// accepted press. Simultaneous multi-key presses are rejected and flagged on multi_err.
module keypad_debounce_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned CNT_W           = 5
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       key_1_raw,
   input  logic       key_2_raw,
   input  logic       key_star_raw,
   output logic [1:0] button_2_1,
   output logic       button_star,
   output logic       multi_err,
   output logic       key_busy
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StDebounce, StEmit, StWaitRel} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       cand_q, cand_d;
   logic [2:0]       sync1_q, sync2_q;
   logic [2:0]       kv;
   logic             one_hot;
   logic [1:0]       btn_q, btn_d;
   logic             star_q, star_d;
   logic             err_q, err_d;

   assign kv      = sync2_q;
   assign one_hot = (kv == 3'b001) || (kv == 3'b010) || (kv == 3'b100);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
         state_q <= StIdle;
         cnt_q   <= '0;
         cand_q  <= 3'b000;
         btn_q   <= 2'b00;
         star_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync1_q <= {key_star_raw, key_2_raw, key_1_raw};
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         btn_q   <= btn_d;
         star_q  <= star_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      case (state_q)
         StIdle: begin
            if (kv != 3'b000) begin
               cnt_d = '0;
               if (one_hot) begin
                  cand_d  = kv;
                  state_d = StDebounce;
               end else begin
                  state_d = StWaitRel;
               end
            end
         end
         StDebounce: begin
            // Any change aborts silently; IDLE re-evaluates kv on the next edge.
            if (kv == cand_q) begin
               if (cnt_q == CntMax) state_d = StEmit;
               else                 cnt_d   = cnt_q + CNT_W'(1);
            end else begin
               state_d = StIdle;
            end
         end
         StEmit: begin
            state_d = StWaitRel;
            cnt_d   = '0;
         end
         StWaitRel: begin
            if (kv == 3'b000) begin
               if (cnt_q == CntMax) state_d = StIdle;
               else                 cnt_d   = cnt_q + CNT_W'(1);
            end else begin
               cnt_d = '0;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      btn_d  = 2'b00;
      star_d = 1'b0;
      err_d  = 1'b0;
      if (state_q == StIdle && kv != 3'b000 && !one_hot) begin
         err_d = 1'b1;
      end
      // Output registers load on the DEBOUNCE->EMIT edge so the pulse spans the EMIT cycle.
      if (state_q == StDebounce && kv == cand_q && cnt_q == CntMax) begin
         btn_d  = cand_q[1:0];
         star_d = cand_q[2];
      end
   end

   assign button_2_1  = btn_q;
   assign button_star = star_q;
   assign multi_err   = err_q;
   assign key_busy    = (state_q != StIdle);

endmodule
